// File: rtl/sram_block_pkg.sv
// Shared helpers for the SRAM macro model: derives the write-enable lane count
// from the row width and enable granularity.
package sram_block_pkg;

  function automatic int num_we(input int width, input int wordsize);
    return width / wordsize;
  endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// Extra read-data pipeline stages behind the array output register; DELAY==0
// collapses to a straight wire.
module sram_read_pipe #(
  parameter int WIDTH = 64,
  parameter int DELAY = 0
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DELAY == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = &{1'b0, clk, i_rst_n};
      assign o_data   = i_data;
    end else begin : g_chain
      for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
        logic [WIDTH-1:0] r_q;
        logic [WIDTH-1:0] w_d;
        if (gi == 0) begin : g_first
          assign w_d = i_data;
        end else begin : g_next
          assign w_d = g_stage[gi-1].r_q;
        end
        always_ff @(posedge clk) begin
          if (!i_rst_n) r_q <= '0;
          else          r_q <= w_d;
        end
      end
      assign o_data = g_stage[DELAY-1].r_q;
    end
  endgenerate

endmodule

// File: rtl/sram_block.sv
// Synchronous 1R1W SRAM model with per-lane write enables, read-first collision
// behaviour and a registered read path of DELAY+1 cycles.
module sram_block
  import sram_block_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int LOGDEPTH = 9,
  parameter int WORDSIZE = 8,
  parameter int DELAY    = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [LOGDEPTH-1:0]         readAddr,
  output logic [WIDTH-1:0]            readData,
  input  logic [LOGDEPTH-1:0]         writeAddr,
  input  logic [WIDTH-1:0]            writeData,
  input  logic [WIDTH/WORDSIZE-1:0]   writeEnable
);

  localparam int NUM_WE = num_we(WIDTH, WORDSIZE);
  localparam int DEPTH  = 1 << LOGDEPTH;

  generate
    if (WIDTH % WORDSIZE != 0) begin : g_bad_width
      $error("sram_block: WIDTH must be a multiple of WORDSIZE");
    end
    if (DELAY < 0) begin : g_bad_delay
      $error("sram_block: DELAY must be non-negative");
    end
  endgenerate

  // Array is deliberately never reset so it maps onto block RAM.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_stage0;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < NUM_WE; i++) begin
        if (writeEnable[i]) begin
          r_mem[writeAddr][i*WORDSIZE +: WORDSIZE] <= writeData[i*WORDSIZE +: WORDSIZE];
        end
      end
    end
  end

  // Same-edge read of the written row returns the old contents (read-first).
  always_ff @(posedge clk) begin
    if (!reset_n) r_rd_stage0 <= '0;
    else          r_rd_stage0 <= r_mem[readAddr];
  end

  sram_read_pipe #(
    .WIDTH (WIDTH),
    .DELAY (DELAY)
  ) u_read_pipe (
    .clk     (clk),
    .i_rst_n (reset_n),
    .i_data  (r_rd_stage0),
    .o_data  (readData)
  );

endmodule

// File: tb/tb_sram_block.sv
// Directed bench for sram_block in data (DELAY 0 and 2) and tag configurations,
// with per-instance scoreboards of expected read data.
module tb_sram_block;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH 64, WORDSIZE 8, DELAY 0
  logic        rst_a;
  logic [8:0]  raddr_a, waddr_a;
  logic [63:0] rdata_a, wdata_a;
  logic [7:0]  we_a;
  // Instance B: WIDTH 64, WORDSIZE 8, DELAY 2
  logic        rst_b;
  logic [8:0]  raddr_b, waddr_b;
  logic [63:0] rdata_b, wdata_b;
  logic [7:0]  we_b;
  // Instance C: tag configuration WIDTH = WORDSIZE = 52
  logic        rst_c;
  logic [8:0]  raddr_c, waddr_c;
  logic [51:0] rdata_c, wdata_c;
  logic [0:0]  we_c;

  sram_block #(.WIDTH(64), .LOGDEPTH(9), .WORDSIZE(8), .DELAY(0)) u_dut_a (
    .clk(clk), .reset_n(rst_a), .readAddr(raddr_a), .readData(rdata_a),
    .writeAddr(waddr_a), .writeData(wdata_a), .writeEnable(we_a));

  sram_block #(.WIDTH(64), .LOGDEPTH(9), .WORDSIZE(8), .DELAY(2)) u_dut_b (
    .clk(clk), .reset_n(rst_b), .readAddr(raddr_b), .readData(rdata_b),
    .writeAddr(waddr_b), .writeData(wdata_b), .writeEnable(we_b));

  sram_block #(.WIDTH(52), .LOGDEPTH(9), .WORDSIZE(52), .DELAY(0)) u_dut_c (
    .clk(clk), .reset_n(rst_c), .readAddr(raddr_c), .readData(rdata_c),
    .writeAddr(waddr_c), .writeData(wdata_c), .writeEnable(we_c));

  typedef struct {
    bit          chk;
    logic [63:0] val;
    string       tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t na, nb, nc;

  int checks = 0;
  int errors = 0;

  task automatic clear_next();
    na.chk = 1'b0; na.val = '0; na.tag = "";
    nb.chk = 1'b0; nb.val = '0; nb.tag = "";
    nc.chk = 1'b0; nc.val = '0; nc.tag = "";
  endtask

  task automatic exp_a(input string t, input logic [63:0] v);
    na.chk = 1'b1; na.val = v; na.tag = t;
  endtask

  task automatic exp_b(input string t, input logic [63:0] v);
    nb.chk = 1'b1; nb.val = v; nb.tag = t;
  endtask

  task automatic exp_c(input string t, input logic [63:0] v);
    nc.chk = 1'b1; nc.val = v; nc.tag = t;
  endtask

  task automatic compare(input exp_t e, input logic [63:0] obs);
    if (e.chk) begin
      checks++;
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s: readData=%h expected=%h", e.tag, obs, e.val);
      end
      $display("check %-18s readData=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  // One clock edge: enqueue this cycle's expectations, then retire whatever
  // has travelled the full read latency of each instance.
  task automatic tick();
    qa.push_back(na);
    qb.push_back(nb);
    qc.push_back(nc);
    clear_next();
    @(posedge clk);
    #1;
    if (qa.size() > 0) compare(qa.pop_front(), rdata_a);
    if (qb.size() > 2) compare(qb.pop_front(), rdata_b);
    if (qc.size() > 0) compare(qc.pop_front(), {12'h000, rdata_c});
    we_a = '0;
    we_b = '0;
    we_c = '0;
  endtask

  initial begin
    clear_next();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    raddr_a = '0; waddr_a = '0; wdata_a = '0; we_a = '0;
    raddr_b = '0; waddr_b = '0; wdata_b = '0; we_b = '0;
    raddr_c = '0; waddr_c = '0; wdata_c = '0; we_c = '0;

    // Reset state: every instance reads 0 while held in reset
    for (int i = 0; i < 2; i++) begin
      exp_a("a_reset", 64'h0);
      exp_b("b_reset", 64'h0);
      exp_c("c_reset", 64'h0);
      tick();
    end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // A: full write, then read back
    waddr_a = 9'd5; wdata_a = 64'h0123_4567_89AB_CDEF; we_a = 8'hFF;
    tick();
    raddr_a = 9'd5;
    exp_a("a_full_write", 64'h0123_4567_89AB_CDEF);
    tick();
    // A: partial write of the low four lanes
    waddr_a = 9'd5; wdata_a = '1; we_a = 8'h0F;
    tick();
    exp_a("a_partial_write", 64'h0123_4567_FFFF_FFFF);
    tick();
    // A: read/write collision is read-first
    waddr_a = 9'd3; wdata_a = {16{4'hA}}; we_a = 8'hFF;
    tick();
    waddr_a = 9'd3; wdata_a = {16{4'h5}}; we_a = 8'hFF; raddr_a = 9'd3;
    exp_a("a_collide_old", {16{4'hA}});
    tick();
    exp_a("a_collide_new", {16{4'h5}});
    tick();
    // A: all-zero enable writes nothing
    waddr_a = 9'd3; wdata_a = 64'hDEAD_BEEF_0000_1111; we_a = 8'h00;
    tick();
    exp_a("a_we_zero", {16{4'h5}});
    tick();

    // B: fill rows 1..3, then back-to-back reads through the DELAY=2 pipe
    for (int r = 1; r <= 3; r++) begin
      waddr_b = 9'(r); wdata_b = 64'(r * 'h11); we_b = 8'hFF;
      tick();
    end
    for (int r = 1; r <= 3; r++) begin
      raddr_b = 9'(r);
      exp_b($sformatf("b_latency_row%0d", r), 64'(r * 'h11));
      tick();
    end
    // B: reset with reads in flight flushes them; write in reset cycle is dropped
    raddr_b = 9'd1;
    tick();
    raddr_b = 9'd2;
    tick();
    for (int i = 0; i < qb.size(); i++) begin
      qb[i].chk = 1'b1;
      qb[i].val = 64'h0;
      qb[i].tag = "b_reset_flush";
    end
    rst_b = 1'b0; waddr_b = 9'd1; wdata_b = 64'hDEAD; we_b = 8'hFF;
    exp_b("b_reset_out", 64'h0);
    tick();
    rst_b = 1'b1;
    raddr_b = 9'd1;
    exp_b("b_kept_row1", 64'h11);
    tick();
    raddr_b = 9'd2;
    exp_b("b_kept_row2", 64'h22);
    tick();

    // C: tag configuration, top row and row 0 independent
    waddr_c = 9'd0; wdata_c = 52'h123; we_c = 1'b1;
    tick();
    waddr_c = 9'd511; wdata_c = 52'hF_FFFF_FFFF_FFFF; we_c = 1'b1;
    tick();
    raddr_c = 9'd511;
    exp_c("c_row511", 64'h000F_FFFF_FFFF_FFFF);
    tick();
    raddr_c = 9'd0;
    exp_c("c_row0", 64'h123);
    tick();

    // Drain the longest pipeline
    for (int i = 0; i < 3; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
